mmio_router: RTL and testbench
==============================

MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 SHALL have parameter NREG, default 3, number of downstream regions (1..8).
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have parameter REG_BASE, default {16'h4C00,16'h1000,16'h0000}, packed NREG*AW inclusive base per region, region 0 in LSBs.
REQ-005 SHALL have parameter REG_LIMIT, default {16'hFFFF,16'h4BFF,16'h0FFF}, packed NREG*AW inclusive limit per region.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, WAIT-cycle bound (1..65535).
REQ-007 SHALL have port clki, input, 1, single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port up_addr, input, AW, request address from CPU.
REQ-010 SHALL have port up_wdata, input, DW, write data.
REQ-011 SHALL have ports up_read and up_write, input, 1 each, single-cycle request strobes.
REQ-012 SHALL have port up_rdata, output, DW, read result, held until next completion.
REQ-013 SHALL have ports up_busy and up_ready, output, 1 each, in-flight flag and one-cycle completion pulse.
REQ-014 SHALL have port up_err, output, 1, error flag of last completed transaction.
REQ-015 SHALL have ports dn_addr (AW) and dn_wdata (DW), output, shared to all regions; dn_addr is the latched address minus the selected region base.
REQ-016 SHALL have ports dn_read and dn_write, output, NREG each, one-hot per-region strobes.
REQ-017 SHALL have port dn_rdata, input, NREG*DW, per-region read data, region 0 in LSBs.
REQ-018 SHALL have ports dn_busy and dn_ready, input, NREG each, per-region handshake.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, WAIT, DONE.
REQ-020 IDLE: on up_read or up_write, SHALL latch address, wdata, direction and region index, then go to ACCESS; up_busy high from the next cycle.
REQ-021 Region match SHALL be BASE<=addr<=LIMIT, unsigned; on overlap the lowest index SHALL win.
REQ-022 Unmapped address SHALL skip to DONE with up_err=1 and up_rdata=0; no dn strobe.
REQ-023 up_read and up_write together SHALL be treated as a request error: DONE, up_err=1, no dn strobe.
REQ-024 ACCESS SHALL assert exactly one dn_read or dn_write bit for exactly one cycle, then go to WAIT.
REQ-025 WAIT SHALL exit to DONE on the first cycle with dn_ready[sel]=1 and dn_busy[sel]=0; on a read it SHALL capture dn_rdata[sel] into up_rdata.
REQ-026 DONE SHALL pulse up_ready for one cycle, drop up_busy, update up_err, and return to IDLE.
REQ-027 Zero-wait slave: request in cycle 0, dn strobe in cycle 1, up_ready in cycle 3.
REQ-028 Requests arriving outside IDLE SHALL be ignored, not queued.
REQ-029 Writes SHALL leave up_rdata unchanged.
REQ-030 dn_addr and dn_wdata SHALL be stable from ACCESS through WAIT.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE on the same edge, including mid-transaction; a pending strobe SHALL be dropped.
REQ-032 On rst, SHALL clear up_rdata=0, up_busy=0, up_ready=0, up_err=0, dn_read=0, dn_write=0, dn_addr=0, dn_wdata=0 and the timeout counter.

Configuration
REQ-033 Macro MMIO_ROUTER_TIMEOUT_EN defined: the WAIT counter SHALL count from 0; reaching TIMEOUT_CYC SHALL go to DONE with up_err=1 and up_rdata=all-ones (reads only).
REQ-034 Macro undefined: WAIT SHALL be unbounded, with no counter logic; up_err arises only from REQ-022 and REQ-023.

Structure
REQ-035 Package mmio_pkg SHALL hold the FSM state encoding, the default region map constants and the default TIMEOUT_CYC.
REQ-036 Sub-module mmio_region_match SHALL be combinational: address in, region index, hit flag and offset out; instantiated once.

Verification
REQ-037 Read 0x1005, region 1 zero-wait, dn_rdata=16'hBEEF -> dn_read=3'b010 in cycle 1, dn_addr=0x0005, up_ready in cycle 3, up_rdata=BEEF, up_err=0.
REQ-038 Write 0x4C10 data 0x1234, region 2 holds dn_busy=1 for 5 cycles -> dn_write=3'b100 for one cycle, dn_addr=0x0010, up_ready 2 cycles after dn_busy falls, up_rdata unchanged.
REQ-039 Overlap map region0 0x0000-0x1FFF, region1 0x1000-0x4BFF, read 0x1800 -> dn_read=3'b001.
REQ-040 Read/write pulsed together, and unmapped address with map ending at 0x7FFF, read 0x9000 -> no dn strobe, up_ready in cycle 2, up_err=1, up_rdata=0 (unmapped case).
REQ-041 MMIO_ROUTER_TIMEOUT_EN defined, TIMEOUT_CYC=4, dn_ready stuck low -> up_err=1, up_rdata=FFFF, up_ready after 4 WAIT cycles; undefined -> up_busy stays high indefinitely.
REQ-042 rst asserted in WAIT -> next cycle IDLE, all outputs zero, a new request accepted normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO router: FSM encoding, default region map
// and default WAIT-cycle bound.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mmio_state_t;

  localparam int unsigned DEF_NREG = 3;

  // Region 0 occupies the least significant 16 bits.
  localparam logic [47:0] DEF_REG_BASE  = {16'h4C00, 16'h1000, 16'h0000};
  localparam logic [47:0] DEF_REG_LIMIT = {16'hFFFF, 16'h4BFF, 16'h0FFF};

  localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mmio_region_match.sv
// Combinational address decoder: finds the region whose inclusive
// [base, limit] window contains the address. Lowest index wins on overlap.
module mmio_region_match
  import mmio_pkg::*;
#(
  parameter int unsigned NREG = DEF_NREG,
  parameter int unsigned AW   = 16,
  parameter int unsigned IW   = 2,
  parameter logic [NREG*AW-1:0] REG_BASE  = DEF_REG_BASE,
  parameter logic [NREG*AW-1:0] REG_LIMIT = DEF_REG_LIMIT
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o,
  output logic [AW-1:0] off_o
);

  // Scan from the top index down so the lowest matching region is kept last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    off_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((addr_i >= REG_BASE[i*AW +: AW]) && (addr_i <= REG_LIMIT[i*AW +: AW])) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
        off_o = addr_i - REG_BASE[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// MMIO router: takes single-cycle CPU read/write strobes, decodes the target
// region, issues a one-cycle strobe downstream and waits for that region's
// handshake before reporting completion upstream.
// Optional: define MMIO_ROUTER_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT_CYC cycles (timeout completes with up_err=1, reads return all-ones).
module mmio_router
  import mmio_pkg::*;
#(
  parameter int unsigned NREG = DEF_NREG,
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16,
  parameter logic [NREG*AW-1:0] REG_BASE  = DEF_REG_BASE,
  parameter logic [NREG*AW-1:0] REG_LIMIT = DEF_REG_LIMIT,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clki,
  input  logic               rst,
  input  logic [AW-1:0]      up_addr,
  input  logic [DW-1:0]      up_wdata,
  input  logic               up_read,
  input  logic               up_write,
  output logic [DW-1:0]      up_rdata,
  output logic               up_busy,
  output logic               up_ready,
  output logic               up_err,
  output logic [AW-1:0]      dn_addr,
  output logic [DW-1:0]      dn_wdata,
  output logic [NREG-1:0]    dn_read,
  output logic [NREG-1:0]    dn_write,
  input  logic [NREG*DW-1:0] dn_rdata,
  input  logic [NREG-1:0]    dn_busy,
  input  logic [NREG-1:0]    dn_ready
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  // Reject out-of-range configurations at elaboration.
  if (NREG < 1 || NREG > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_cfg_check
    $error("mmio_router: NREG or TIMEOUT_CYC out of range");
  end

  mmio_state_t state_q, state_d;

  logic [AW-1:0] off_q;
  logic [DW-1:0] wdata_q;
  logic          dir_wr_q;
  logic [IW-1:0] sel_q;
  logic          hit_q;
  logic          rqerr_q;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          m_hit;
  logic [IW-1:0] m_idx;
  logic [AW-1:0] m_off;
  logic          req;
  logic          slv_done;
  logic [DW-1:0] rd_sel;

  mmio_region_match #(
    .NREG      (NREG),
    .AW        (AW),
    .IW        (IW),
    .REG_BASE  (REG_BASE),
    .REG_LIMIT (REG_LIMIT)
  ) u_match (
    .addr_i (up_addr),
    .hit_o  (m_hit),
    .idx_o  (m_idx),
    .off_o  (m_off)
  );

  assign req      = up_read | up_write;
  assign slv_done = dn_ready[sel_q] & ~dn_busy[sel_q];
  assign rd_sel   = dn_rdata[sel_q*DW +: DW];

`ifdef MMIO_ROUTER_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        to_hit;

  assign to_hit = (to_cnt_q == 16'(TIMEOUT_CYC - 1));

  // Counts WAIT cycles; restarts from zero whenever the FSM is elsewhere.
  always_ff @(posedge clki) begin
    if (rst || state_q != ST_WAIT) to_cnt_q <= '0;
    else                           to_cnt_q <= to_cnt_q + 16'd1;
  end
`endif

  // State and completion result registers.
  always_ff @(posedge clki) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture: only an idle router accepts, so strobes elsewhere are dropped.
  always_ff @(posedge clki) begin
    if (rst) begin
      off_q    <= '0;
      wdata_q  <= '0;
      dir_wr_q <= 1'b0;
      sel_q    <= '0;
      hit_q    <= 1'b0;
      rqerr_q  <= 1'b0;
    end else if (state_q == ST_IDLE && req) begin
      off_q    <= m_off;
      wdata_q  <= up_wdata;
      dir_wr_q <= up_write;
      sel_q    <= m_idx;
      hit_q    <= m_hit;
      rqerr_q  <= up_read & up_write;
    end
  end

  // Next-state and completion result; error cases bypass WAIT without a strobe.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!hit_q || rqerr_q) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!hit_q) rdata_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (slv_done) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (!dir_wr_q) rdata_d = rd_sel;
        end
`ifdef MMIO_ROUTER_TIMEOUT_EN
        else if (to_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!dir_wr_q) rdata_d = '1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; strobes only in ACCESS for a valid request.
  always_comb begin
    up_busy  = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
    up_ready = (state_q == ST_DONE);
    up_rdata = rdata_q;
    up_err   = err_q;
    dn_addr  = off_q;
    dn_wdata = wdata_q;
    dn_read  = '0;
    dn_write = '0;
    if (state_q == ST_ACCESS && hit_q && !rqerr_q) begin
      if (dir_wr_q) dn_write = NREG'(1) << sel_q;
      else          dn_read  = NREG'(1) << sel_q;
    end
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router. Two instances share the upstream and
// downstream stimulus: u_dut uses the default map, u_ovl an overlapping map
// that ends at 0x7FFF.
module tb_mmio_router;

  localparam int NREG = 3;
  localparam int AW   = 16;
  localparam int DW   = 16;
`ifdef MMIO_ROUTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam logic [47:0] OVL_BASE  = {16'h4C00, 16'h1000, 16'h0000};
  localparam logic [47:0] OVL_LIMIT = {16'h7FFF, 16'h4BFF, 16'h1FFF};

  logic                clki = 1'b0;
  logic                rst;
  logic [AW-1:0]       up_addr;
  logic [DW-1:0]       up_wdata;
  logic                up_read, up_write;
  logic [NREG*DW-1:0]  dn_rdata;
  logic [NREG-1:0]     dn_busy, dn_ready;

  logic [DW-1:0]       up_rdata, o_up_rdata;
  logic                up_busy, up_ready, up_err;
  logic                o_up_busy, o_up_ready, o_up_err;
  logic [AW-1:0]       dn_addr, o_dn_addr;
  logic [DW-1:0]       dn_wdata, o_dn_wdata;
  logic [NREG-1:0]     dn_read, dn_write, o_dn_read, o_dn_write;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clki = ~clki;

  mmio_router #(.NREG(NREG), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) u_dut (
    .clki(clki), .rst(rst), .up_addr(up_addr), .up_wdata(up_wdata),
    .up_read(up_read), .up_write(up_write), .up_rdata(up_rdata),
    .up_busy(up_busy), .up_ready(up_ready), .up_err(up_err),
    .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_read(dn_read), .dn_write(dn_write),
    .dn_rdata(dn_rdata), .dn_busy(dn_busy), .dn_ready(dn_ready)
  );

  mmio_router #(.NREG(NREG), .AW(AW), .DW(DW), .REG_BASE(OVL_BASE),
                .REG_LIMIT(OVL_LIMIT), .TIMEOUT_CYC(TO)) u_ovl (
    .clki(clki), .rst(rst), .up_addr(up_addr), .up_wdata(up_wdata),
    .up_read(up_read), .up_write(up_write), .up_rdata(o_up_rdata),
    .up_busy(o_up_busy), .up_ready(o_up_ready), .up_err(o_up_err),
    .dn_addr(o_dn_addr), .dn_wdata(o_dn_wdata), .dn_read(o_dn_read), .dn_write(o_dn_write),
    .dn_rdata(dn_rdata), .dn_busy(dn_busy), .dn_ready(dn_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; drive and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  // Pulse a request for one cycle; returns in the cycle after the strobe.
  task automatic req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    up_read  = rd;
    up_write = wr;
    up_addr  = a;
    up_wdata = d;
    tick();
    up_read  = 1'b0;
    up_write = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    up_addr  = '0;
    up_wdata = '0;
    up_read  = 1'b0;
    up_write = 1'b0;
    dn_busy  = '0;
    dn_ready = '1;
    dn_rdata = {16'h7777, 16'hBEEF, 16'hA5A5};
    tick();
    tick();
    chk("rst_busy",  {31'd0, up_busy},  32'd0);
    chk("rst_ready", {31'd0, up_ready}, 32'd0);
    chk("rst_err",   {31'd0, up_err},   32'd0);
    chk("rst_rdata", {16'd0, up_rdata}, 32'd0);
    chk("rst_strb",  {26'd0, dn_read, dn_write}, 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait read of region 1.
    req(1'b1, 1'b0, 16'h1005, 16'h0000);
    chk("rd_dn_read_c1", {29'd0, dn_read}, 32'h2);
    chk("rd_dn_write_c1", {29'd0, dn_write}, 32'h0);
    chk("rd_dn_addr_c1", {16'd0, dn_addr}, 32'h0005);
    chk("rd_busy_c1", {31'd0, up_busy}, 32'd1);
    chk("ovl_rd_dn_read_c1", {29'd0, o_dn_read}, 32'h1);
    tick();
    chk("rd_dn_read_c2", {29'd0, dn_read}, 32'h0);
    chk("rd_ready_c2", {31'd0, up_ready}, 32'd0);
    tick();
    chk("rd_ready_c3", {31'd0, up_ready}, 32'd1);
    chk("rd_rdata_c3", {16'd0, up_rdata}, 32'hBEEF);
    chk("rd_err_c3", {31'd0, up_err}, 32'd0);
    chk("rd_busy_c3", {31'd0, up_busy}, 32'd0);
    chk("ovl_rd_rdata_c3", {16'd0, o_up_rdata}, 32'hA5A5);
    tick();
    chk("rd_ready_c4", {31'd0, up_ready}, 32'd0);
    chk("rd_rdata_hold", {16'd0, up_rdata}, 32'hBEEF);

    // Write to region 2 with a slow slave; a stray read during WAIT is ignored.
    dn_busy[2]  = 1'b1;
    dn_ready[2] = 1'b0;
    req(1'b0, 1'b1, 16'h4C10, 16'h1234);
    chk("wr_dn_write_c1", {29'd0, dn_write}, 32'h4);
    chk("wr_dn_read_c1", {29'd0, dn_read}, 32'h0);
    chk("wr_dn_addr_c1", {16'd0, dn_addr}, 32'h0010);
    chk("wr_dn_wdata_c1", {16'd0, dn_wdata}, 32'h1234);
    tick();
    chk("wr_dn_write_c2", {29'd0, dn_write}, 32'h0);
    tick();
    up_read = 1'b1;
    up_addr = 16'h1005;
    tick();
    up_read = 1'b0;
    chk("wr_ignore_dn_read_c4", {29'd0, dn_read}, 32'h0);
    chk("wr_dn_addr_stable_c4", {16'd0, dn_addr}, 32'h0010);
    chk("wr_dn_wdata_stable_c4", {16'd0, dn_wdata}, 32'h1234);
    tick();
    tick();
    dn_busy[2] = 1'b0;
    tick();
    dn_ready[2] = 1'b1;
    chk("wr_ready_c7", {31'd0, up_ready}, 32'd0);
    chk("wr_busy_c7", {31'd0, up_busy}, 32'd1);
    tick();
    chk("wr_ready_c8", {31'd0, up_ready}, 32'd1);
    chk("wr_rdata_unchanged", {16'd0, up_rdata}, 32'hBEEF);
    chk("wr_err_c8", {31'd0, up_err}, 32'd0);
    tick();
    chk("wr_no_queued_busy", {31'd0, up_busy}, 32'd0);
    chk("wr_no_queued_strb", {29'd0, dn_read}, 32'h0);

    // Read and write strobed together.
    req(1'b1, 1'b1, 16'h1005, 16'h0000);
    chk("both_strb_c1", {26'd0, dn_read, dn_write}, 32'h0);
    tick();
    chk("both_ready_c2", {31'd0, up_ready}, 32'd1);
    chk("both_err_c2", {31'd0, up_err}, 32'd1);
    chk("both_busy_c2", {31'd0, up_busy}, 32'd0);
    tick();

    // 0x9000: unmapped for u_ovl, region 2 for u_dut.
    req(1'b1, 1'b0, 16'h9000, 16'h0000);
    chk("unm_ovl_strb_c1", {26'd0, o_dn_read, o_dn_write}, 32'h0);
    chk("unm_dut_dn_read_c1", {29'd0, dn_read}, 32'h4);
    chk("unm_dut_dn_addr_c1", {16'd0, dn_addr}, 32'h4400);
    tick();
    chk("unm_ovl_ready_c2", {31'd0, o_up_ready}, 32'd1);
    chk("unm_ovl_err_c2", {31'd0, o_up_err}, 32'd1);
    chk("unm_ovl_rdata_c2", {16'd0, o_up_rdata}, 32'h0000);
    tick();
    chk("unm_dut_ready_c3", {31'd0, up_ready}, 32'd1);
    chk("unm_dut_rdata_c3", {16'd0, up_rdata}, 32'h7777);
    chk("unm_dut_err_clr_c3", {31'd0, up_err}, 32'd0);
    tick();

    // Overlap: 0x1800 lies in regions 0 and 1 of u_ovl; region 0 wins.
    req(1'b1, 1'b0, 16'h1800, 16'h0000);
    chk("ovl_dn_read_c1", {29'd0, o_dn_read}, 32'h1);
    chk("ovl_dn_addr_c1", {16'd0, o_dn_addr}, 32'h1800);
    chk("ovl_dut_dn_read_c1", {29'd0, dn_read}, 32'h2);
    chk("ovl_dut_dn_addr_c1", {16'd0, dn_addr}, 32'h0800);
    tick();
    tick();
    chk("ovl_rdata_c3", {16'd0, o_up_rdata}, 32'hA5A5);
    chk("ovl_err_clr_c3", {31'd0, o_up_err}, 32'd0);
    tick();

    // Slave never ready.
    dn_ready = '0;
    req(1'b1, 1'b0, 16'h1005, 16'h5A5A);
`ifdef MMIO_ROUTER_TIMEOUT_EN
    repeat (4) tick();
    chk("to_ready_c5", {31'd0, up_ready}, 32'd0);
    tick();
    chk("to_ready_c6", {31'd0, up_ready}, 32'd1);
    chk("to_err_c6", {31'd0, up_err}, 32'd1);
    chk("to_rdata_c6", {16'd0, up_rdata}, 32'hFFFF);
    tick();
    chk("to_busy_c7", {31'd0, up_busy}, 32'd0);
    req(1'b1, 1'b0, 16'h1005, 16'h5A5A);
    tick();
`else
    repeat (60) tick();
    chk("stuck_busy", {31'd0, up_busy}, 32'd1);
    chk("stuck_ready", {31'd0, up_ready}, 32'd0);
`endif

    // Reset while in WAIT.
    chk("wait_busy_pre_rst", {31'd0, up_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dn_ready = '1;
    chk("rstw_busy", {31'd0, up_busy}, 32'd0);
    chk("rstw_ready", {31'd0, up_ready}, 32'd0);
    chk("rstw_err", {31'd0, up_err}, 32'd0);
    chk("rstw_rdata", {16'd0, up_rdata}, 32'h0000);
    chk("rstw_strb", {26'd0, dn_read, dn_write}, 32'h0);
    chk("rstw_dn_addr", {16'd0, dn_addr}, 32'h0000);
    chk("rstw_dn_wdata", {16'd0, dn_wdata}, 32'h0000);
    req(1'b1, 1'b0, 16'h1005, 16'h0000);
    chk("post_rst_dn_read_c1", {29'd0, dn_read}, 32'h2);
    tick();
    tick();
    chk("post_rst_ready_c3", {31'd0, up_ready}, 32'd1);
    chk("post_rst_rdata_c3", {16'd0, up_rdata}, 32'hBEEF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
